// File: rtl/conv_sequencer.sv
// Load-then-convolve sequencer: streams a 4x4 matrix and 3x3 filter into memory, then produces
// a 2x2 valid convolution through the serial output memory. Define CONV_SAT_EN to saturate results.
module conv_sequencer #(
   parameter int unsigned OUT_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] data_w,
   output logic [3:0] addr_A0,
   output logic [3:0] addr_A1,
   output logic [3:0] addr_A2,
   output logic [3:0] addr_F0,
   output logic [3:0] addr_F1,
   output logic [3:0] addr_F2,
   output logic [1:0] addr_S0,
   output logic [1:0] en_INP,
   output logic [1:0] en_FIL,
   output logic [1:0] en_S,
   input  logic [7:0] out_A0,
   input  logic [7:0] out_A1,
   input  logic [7:0] out_A2,
   input  logic [7:0] out_F0,
   input  logic [7:0] out_F1,
   input  logic [7:0] out_F2,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadF,
      StIssue,
      StDrain,
      StWrite,
      StDone
   } state_t;

   localparam logic [1:0] EnWrite = 2'b11;
   localparam logic [1:0] EnRead  = 2'b10;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [1:0]  pix_q;
   logic [1:0]  row_q;
   logic [19:0] acc_q;

   logic        hs;
   logic [19:0] prod_sum;
   logic [3:0]  row_base;
   logic [3:0]  fil_base;
   logic [7:0]  result;

   assign hs = in_valid & in_ready;

   // Read data arriving now belongs to the row issued in the previous cycle.
   assign prod_sum = {12'd0, out_A0} * {12'd0, out_F0}
                   + {12'd0, out_A1} * {12'd0, out_F1}
                   + {12'd0, out_A2} * {12'd0, out_F2};

   assign row_base = {2'({1'b0, pix_q[1]} + row_q), 2'b00} + {3'd0, pix_q[0]};
   assign fil_base = {1'b0, row_q, 1'b0} + {2'd0, row_q};

`ifdef CONV_SAT_EN
   logic [19:0] shifted;
   assign shifted = acc_q >> OUT_SHIFT;
   assign result  = (|shifted[19:8]) ? 8'hff : shifted[7:0];
`else
   assign result  = 8'(acc_q >> OUT_SHIFT);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pix_q   <= '0;
         row_q   <= '0;
         acc_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               pix_q <= '0;
               row_q <= '0;
               acc_q <= '0;
               if (start) state_q <= StLoadA;
            end
            StLoadA: begin
               if (hs) begin
                  if (cnt_q == 4'd15) begin
                     cnt_q   <= '0;
                     state_q <= StLoadF;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            StLoadF: begin
               if (hs) begin
                  if (cnt_q == 4'd8) begin
                     cnt_q   <= '0;
                     pix_q   <= '0;
                     row_q   <= '0;
                     state_q <= StIssue;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            StIssue: begin
               // Row 0 has no data in flight yet, so it starts the pixel from zero.
               acc_q <= (row_q == 2'd0) ? 20'd0 : acc_q + prod_sum;
               if (row_q == 2'd2) begin
                  row_q   <= '0;
                  state_q <= StDrain;
               end else begin
                  row_q <= row_q + 2'd1;
               end
            end
            StDrain: begin
               acc_q   <= acc_q + prod_sum;
               state_q <= StWrite;
            end
            StWrite: begin
               if (pix_q == 2'd3) begin
                  state_q <= StDone;
               end else begin
                  pix_q   <= pix_q + 2'd1;
                  state_q <= StIssue;
               end
            end
            StDone: begin
               pix_q   <= '0;
               acc_q   <= '0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b0;
      data_w   = '0;
      addr_A0  = '0;
      addr_A1  = '0;
      addr_A2  = '0;
      addr_F0  = '0;
      addr_F1  = '0;
      addr_F2  = '0;
      addr_S0  = '0;
      en_INP   = '0;
      en_FIL   = '0;
      en_S     = '0;
      busy     = (state_q != StIdle);
      done     = (state_q == StDone);
      unique case (state_q)
         StLoadA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               en_INP  = EnWrite;
               addr_A0 = cnt_q;
               data_w  = in_data;
            end
         end
         StLoadF: begin
            in_ready = 1'b1;
            if (in_valid) begin
               en_FIL  = EnWrite;
               addr_F0 = cnt_q;
               data_w  = in_data;
            end
         end
         StIssue: begin
            en_INP  = EnRead;
            en_FIL  = EnRead;
            addr_A0 = row_base;
            addr_A1 = row_base + 4'd1;
            addr_A2 = row_base + 4'd2;
            addr_F0 = fil_base;
            addr_F1 = fil_base + 4'd1;
            addr_F2 = fil_base + 4'd2;
         end
         StWrite: begin
            en_S    = EnWrite;
            addr_S0 = pix_q;
            data_w  = result;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: memory model, 2x2 convolution reference, write-order checks.
module tb_conv_sequencer;

   localparam int unsigned SHIFT = 1;

   logic       clk = 1'b0;
   logic       rst, start, in_valid;
   logic [7:0] in_data;
   logic       in_ready, busy, done;
   logic [7:0] data_w;
   logic [3:0] addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2;
   logic [1:0] addr_S0, en_INP, en_FIL, en_S;
   logic [7:0] out_A0, out_A1, out_A2, out_F0, out_F1, out_F2;

   conv_sequencer #(.OUT_SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .data_w(data_w),
      .addr_A0(addr_A0), .addr_A1(addr_A1), .addr_A2(addr_A2),
      .addr_F0(addr_F0), .addr_F1(addr_F1), .addr_F2(addr_F2), .addr_S0(addr_S0),
      .en_INP(en_INP), .en_FIL(en_FIL), .en_S(en_S),
      .out_A0(out_A0), .out_A1(out_A1), .out_A2(out_A2),
      .out_F0(out_F0), .out_F1(out_F1), .out_F2(out_F2),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous memories with one-cycle read latency.
   logic [7:0] mem_a [16];
   logic [7:0] mem_f [16];
   always @(posedge clk) begin
      if (en_INP == 2'b11) mem_a[addr_A0] <= data_w;
      if (en_FIL == 2'b11) mem_f[addr_F0] <= data_w;
      if (en_INP == 2'b10) begin
         out_A0 <= mem_a[addr_A0];
         out_A1 <= mem_a[addr_A1];
         out_A2 <= mem_a[addr_A2];
      end
      if (en_FIL == 2'b10) begin
         out_F0 <= mem_f[addr_F0];
         out_F1 <= mem_f[addr_F1];
         out_F2 <= mem_f[addr_F2];
      end
   end

   typedef struct packed {int kind; int addr; int data;} wr_t;  // kind: 0=A 1=F 2=S
   wr_t exp_q[$];

   int checks = 0, errors = 0;
   int cyc = 0, done_cnt = 0, last_f_cyc = 0, f_seen = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic any_out();
      return busy | done | in_ready | (|en_INP) | (|en_FIL) | (|en_S) | (|data_w) |
             (|addr_A0) | (|addr_A1) | (|addr_A2) | (|addr_F0) | (|addr_F1) | (|addr_F2) |
             (|addr_S0);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every memory write pops the next expected write.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         int kind, addr, nwr;
         wr_t e;
         kind = -1; addr = 0;
         nwr = int'(en_INP == 2'b11) + int'(en_FIL == 2'b11) + int'(en_S == 2'b11);
         if (nwr > 1) check("single_write", nwr, 1);
         if (en_INP == 2'b11) begin kind = 0; addr = int'(addr_A0); end
         if (en_FIL == 2'b11) begin kind = 1; addr = int'(addr_F0); end
         if (en_S == 2'b11)   begin kind = 2; addr = int'(addr_S0); end
         if (kind >= 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", kind, -1);
            end else begin
               e = exp_q.pop_front();
               check("write_kind", kind, e.kind);
               check("write_addr", addr, e.addr);
               check("write_data", int'(data_w), e.data);
            end
         end
         if (en_FIL == 2'b11) begin
            f_seen++;
            if (f_seen == 9) begin
               last_f_cyc = cyc;
               f_seen = 0;
            end
         end
         if (done) begin
            done_cnt++;
            check("done_latency", cyc - last_f_cyc, 21);
         end
         if (en_S == 2'b11 || en_INP == 2'b10) check("in_ready_outside_load", int'(in_ready), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pat: 0 ramp/ramp+1, 1 all ones, 2 random, 3 all 255
   // gap: 0 continuous, 1 alternate cycles, 2 random gaps
   task automatic run_job(input int pat, input int gap, input bit poke_start, input bit abort);
      logic [7:0] a [16];
      logic [7:0] f [9];
      int res [4];
      int words [25];
      int t, d0;
      for (int i = 0; i < 16; i++)
         a[i] = (pat == 0) ? 8'(i) : (pat == 1) ? 8'd1 : (pat == 3) ? 8'hff : 8'($urandom);
      for (int k = 0; k < 9; k++)
         f[k] = (pat == 0) ? 8'(k + 1) : (pat == 1) ? 8'd1 : (pat == 3) ? 8'hff : 8'($urandom);
      for (int p = 0; p < 4; p++) begin
         int acc, sh;
         acc = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               acc += int'(a[((p / 2) + r) * 4 + (p % 2) + c]) * int'(f[r * 3 + c]);
         sh = acc >> SHIFT;
`ifdef CONV_SAT_EN
         res[p] = (sh > 255) ? 255 : sh;
`else
         res[p] = sh % 256;
`endif
      end
      for (int i = 0; i < 16; i++) begin
         words[i] = int'(a[i]);
         exp_q.push_back('{kind: 0, addr: i, data: int'(a[i])});
      end
      for (int k = 0; k < 9; k++) begin
         words[16 + k] = int'(f[k]);
         exp_q.push_back('{kind: 1, addr: k, data: int'(f[k])});
      end
      for (int p = 0; p < (abort ? 1 : 4); p++)
         exp_q.push_back('{kind: 2, addr: p, data: res[p]});

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 25; i++) begin
         int g;
         g = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 3));
         in_valid = 1'b0;
         repeat (g) tick();
         in_valid = 1'b1;
         in_data  = 8'(words[i]);
         t = 0;
         while (!in_ready && t < 50) begin
            tick();
            t++;
         end
         if (!in_ready) check("in_ready_timeout", 0, 1);
         tick();
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);

      if (abort) begin
         repeat (6) tick();
         #2 rst = 1'b1;
         #1 check("abort_outputs_zero", int'(any_out()), 0);
         tick();
         tick();
         rst = 1'b0;
         check("abort_no_pending_writes", exp_q.size(), 0);
         check("abort_idle", int'(busy), 0);
         exp_q.delete();
      end else begin
         d0 = done_cnt;
         if (poke_start) begin
            repeat (3) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         t = 0;
         while (done_cnt == d0 && t < 200) begin
            tick();
            t++;
         end
         repeat (3) tick();
         check("done_pulses", done_cnt - d0, 1);
         check("idle_after_job", int'(busy), 0);
         check("all_writes_seen", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      #1 check("reset_outputs_zero", int'(any_out()), 0);
      repeat (3) tick();
      rst = 1'b0;
      check("idle_after_reset", int'(any_out()), 0);
      start = 1'b0;
      repeat (2) tick();
      check("idle_without_start", int'(busy), 0);

      run_job(0, 0, 1'b0, 1'b0);
      run_job(1, 0, 1'b0, 1'b0);
      run_job(2, 1, 1'b0, 1'b0);
      run_job(2, 2, 1'b1, 1'b0);
      run_job(3, 0, 1'b0, 1'b0);
      run_job(2, 0, 1'b0, 1'b1);
      run_job(0, 2, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) run_job(2, int'($urandom_range(0, 2)), j[0], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual %0t required finish", $time);
      $fatal(1);
   end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter OUT_SHIFT, default 0: right-shift applied to the 20-bit accumulator before the 8-bit result is formed.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begins one load+convolve job when sampled high in IDLE.
REQ-005 in_valid  input  1  in_data holds a valid word.
REQ-006 in_data  input  8  load stream: 16 matrix words (A0..A15), then 9 filter words (F0..F8), all row-major.
REQ-007 in_ready  output  1  the sequencer accepts in_data this cycle.
REQ-008 data_w  output  8  write data to the memory module.
REQ-009 addr_A0, addr_A1, addr_A2  output  4 each  matrix read/write addresses.
REQ-010 addr_F0, addr_F1, addr_F2  output  4 each  filter read/write addresses.
REQ-011 addr_S0  output  2  serial output memory write address.
REQ-012 en_INP, en_FIL, en_S  output  2 each  memory enables: 11 = write, 10 = read, 00 = idle.
REQ-013 out_A0..out_A2, out_F0..out_F2  input  8 each  memory read data, valid one clk after the read address and enable.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_A, LOAD_F, ISSUE, DRAIN, WRITE, DONE.
REQ-017 IDLE->LOAD_A on start; start SHALL be ignored in every other state.
REQ-018 In LOAD_A/LOAD_F: in_ready=1; a handshake (in_valid & in_ready) drives en_INP=11 (resp. en_FIL=11), addr_A0 (resp. addr_F0)=load count, data_w=in_data in the same cycle; the count advances only on a handshake.
REQ-019 LOAD_A->LOAD_F after handshake 16; LOAD_F->ISSUE after handshake 9; gaps in in_valid SHALL stall without writing.
REQ-020 Output pixel p=0..3, pr=p>>1, pc=p&1; ISSUE spends 3 cycles, r=0..2: en_INP=en_FIL=10, addr_Aj=(pr+r)*4+pc+j, addr_Fj=r*3+j, j=0..2.
REQ-021 Each cycle after an ISSUE cycle SHALL add out_A0*out_F0+out_A1*out_F1+out_A2*out_F2 (unsigned) to a 20-bit accumulator cleared at pixel start; DRAIN (1 cycle) adds the row-2 products.
REQ-022 WRITE (1 cycle): en_S=11, addr_S0=p, data_w=result; then ISSUE for p+1, or DONE after p=3.
REQ-023 Each pixel SHALL take exactly 5 cycles; the convolution phase takes 20 cycles.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 Outside the cases above, all enables SHALL be 00, and all addresses and data_w SHALL be 0.

Reset
REQ-026 rst SHALL force IDLE, counters and accumulator 0, in_ready=busy=done=0, all enables 00, all addresses and data_w 0, independent of clk.
REQ-027 rst asserted mid-job SHALL abandon the job without further memory writes; a new start after release SHALL restart at LOAD_A.

Configuration
REQ-028 With CONV_SAT_EN defined, result = min(acc>>OUT_SHIFT, 255); without it, result = (acc>>OUT_SHIFT)[7:0] (truncation).

Verification
REQ-029 A[i]=i, F[k]=k+1, OUT_SHIFT=2, continuous in_valid -> S writes 75, 87, 120, 132 at addr_S0 0..3; done exactly 21 cycles after the 9th filter handshake.
REQ-030 Same data, OUT_SHIFT=1 -> S = 151, 174, 241, 255 with CONV_SAT_EN; 151, 174, 241, 8 without it.
REQ-031 in_valid high on alternate cycles -> exactly 25 writes, addresses 0..15 then 0..8 with no skips or repeats; in_ready low outside the load states.
REQ-032 All A=1, all F=1, OUT_SHIFT=0 -> four S writes of 9.
REQ-033 start pulsed during ISSUE -> no effect: the job completes normally with one done pulse.
REQ-034 rst asserted during the second pixel's ISSUE -> all outputs 0 immediately; no en_S=11 until a new job reaches WRITE.
